// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use
// stall detection and branch-flush bubbles feeding the EX ALU.
//
// Ports:
//   clk, reset            : rising-edge clock, sync active-high reset
//   id_*                  : decoded instruction from ID
//   flush                 : branch taken, kill instruction entering EX
//   mem_*/wb_*            : EX/MEM and MEM/WB write-back bypass sources
//   stall                 : load-use hazard, hold PC and IF/ID
//   ex_*                  : registered/forwarded operands and control to EX
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [2:0]    id_alu_op,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_dst,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_result,
  output logic          stall,
  output logic          ex_valid,
  output logic [2:0]    ex_alu_op,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [4:0]    ex_shamt,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
);

  typedef struct packed {
    logic          valid;
    logic [2:0]    alu_op;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dst;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } ex_t;

  ex_t ex_q;
  ex_t ex_d;

  logic          bubble;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // Conservative: rt is compared even for instructions not reading it.
  assign stall = id_valid
               & ex_q.valid
               & ex_q.mem_read
               & (ex_q.dst != '0)
               & ((ex_q.dst == id_rs) | (ex_q.dst == id_rt));

  assign bubble = stall | flush;

  always_comb begin
    ex_d            = '0;
    ex_d.valid      = id_valid;
    ex_d.alu_op     = id_alu_op;
    ex_d.rs         = id_rs;
    ex_d.rt         = id_rt;
    ex_d.dst        = id_reg_dst ? id_rd : id_rt;
    ex_d.rs_data    = id_rs_data;
    ex_d.rt_data    = id_rt_data;
    ex_d.imm        = id_imm;
    ex_d.shamt      = id_shamt;
    ex_d.alu_src    = id_alu_src;
    ex_d.reg_write  = id_reg_write;
    ex_d.mem_read   = id_mem_read;
    ex_d.mem_write  = id_mem_write;
    ex_d.mem_to_reg = id_mem_to_reg;
    if (bubble) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // The younger producer (EX/MEM) wins over MEM/WB; r0 never bypasses.
  always_comb begin
    fwd_rs = ex_q.rs_data;
    if (mem_reg_write && mem_dst != '0
        && mem_dst == ex_q.rs) begin
      fwd_rs = mem_result;
    end else if (wb_reg_write && wb_dst != '0
                 && wb_dst == ex_q.rs) begin
      fwd_rs = wb_result;
    end
  end

  always_comb begin
    fwd_rt = ex_q.rt_data;
    if (mem_reg_write && mem_dst != '0
        && mem_dst == ex_q.rt) begin
      fwd_rt = mem_result;
    end else if (wb_reg_write && wb_dst != '0
                 && wb_dst == ex_q.rt) begin
      fwd_rt = wb_result;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_a          = fwd_rs;
  assign ex_b          = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign ex_shamt      = ex_q.shamt;
  assign ex_store_data = fwd_rt;
  assign ex_dst        = ex_q.dst;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus
// randomized traffic against a behavioural EX-slot model.
module tb_id_ex_stage;

  logic        clk = 0;
  logic        reset;
  logic        id_valid;
  logic [2:0]  id_alu_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic        id_alu_src, id_reg_dst;
  logic        id_reg_write, id_mem_read;
  logic        id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        mem_reg_write;
  logic [4:0]  mem_dst;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_dst;
  logic [31:0] wb_result;
  logic        stall, ex_valid;
  logic [2:0]  ex_alu_op;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_shamt, ex_dst;
  logic        ex_reg_write, ex_mem_read;
  logic        ex_mem_write, ex_mem_to_reg;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
    .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .wb_result(wb_result),
    .stall(stall), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_shamt(ex_shamt), .ex_store_data(ex_store_data),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg)
  );

  logic [114:0] dut_vec;
  assign dut_vec = {stall, ex_valid, ex_alu_op, ex_a, ex_b,
                    ex_shamt, ex_store_data, ex_dst,
                    ex_reg_write, ex_mem_read,
                    ex_mem_write, ex_mem_to_reg};

  // What the EX slot should hold, expressed as an instruction record.
  typedef struct packed {
    logic        v;
    logic [2:0]  op;
    logic [4:0]  rs, rt, dst;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  sh;
    logic        src, rw, mr, mw, m2r;
  } exm_t;

  exm_t m = '0;

  function automatic logic [31:0] fwd(input logic [4:0] r,
                                      input logic [31:0] d);
    if (mem_reg_write && mem_dst != 0 && mem_dst == r)
      return mem_result;
    if (wb_reg_write && wb_dst != 0 && wb_dst == r)
      return wb_result;
    return d;
  endfunction

  function automatic logic m_stall();
    return id_valid && m.v && m.mr && m.dst != 0
           && (m.dst == id_rs || m.dst == id_rt);
  endfunction

  function automatic logic [114:0] exp_vec();
    logic [31:0] a, rt;
    a  = fwd(m.rs, m.rsd);
    rt = fwd(m.rt, m.rtd);
    return {m_stall(), m.v, m.op, a, m.src ? m.imm : rt,
            m.sh, rt, m.dst, m.rw, m.mr, m.mw, m.m2r};
  endfunction

  task automatic step();
    exm_t n;
    n = '0;
    if (!(reset || flush || m_stall())) begin
      n.v   = id_valid;   n.op  = id_alu_op;
      n.rs  = id_rs;      n.rt  = id_rt;
      n.dst = id_reg_dst ? id_rd : id_rt;
      n.rsd = id_rs_data; n.rtd = id_rt_data;
      n.imm = id_imm;     n.sh  = id_shamt;
      n.src = id_alu_src; n.rw  = id_reg_write;
      n.mr  = id_mem_read; n.mw = id_mem_write;
      n.m2r = id_mem_to_reg;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_alu_op = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_shamt = 0; id_alu_src = 0; id_reg_dst = 0;
    id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0;
    flush = 0; reset = 0;
    mem_reg_write = 0; mem_dst = 0; mem_result = 0;
    wb_reg_write = 0; wb_dst = 0; wb_result = 0;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom); id_alu_op = 3'($urandom);
    id_rs = 5'($urandom_range(0, 7));
    id_rt = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7));
    id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm = $urandom; id_shamt = 5'($urandom);
    id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
    id_reg_write = 1'($urandom);
    id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
  endtask

  task automatic test_reset();
    clear_inputs();
    rand_id();
    flush = 1'($urandom);
    reset = 1;
    step();
    step();
    checks++;
    if (dut_vec !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %h want 0", dut_vec);
    end
    clear_inputs();
    id_valid = 1; id_alu_op = 3'b010;
    id_rs = 1; id_rs_data = 5;
    id_rt = 2; id_rt_data = 7;
    id_reg_dst = 1; id_rd = 3; id_reg_write = 1;
    step();
    checks++;
    if (ex_a !== 32'd5 || ex_b !== 32'd7
        || ex_alu_op !== 3'b010 || ex_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_add got a=%h b=%h op=%b v=%b",
               ex_a, ex_b, ex_alu_op, ex_valid);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    id_valid = 1; id_alu_op = 3'b010;
    id_rs = 3; id_rs_data = 32'h33;
    step();
    mem_reg_write = 1; mem_dst = 3; mem_result = 32'h10;
    wb_reg_write = 1; wb_dst = 3; wb_result = 32'h20;
    #1;
    checks++;
    if (ex_a !== 32'h10) begin
      fails++;
      $display("FAIL fwd_mem_prio got %h want 10", ex_a);
    end
    mem_reg_write = 0;
    #1;
    checks++;
    if (ex_a !== 32'h20) begin
      fails++;
      $display("FAIL fwd_wb got %h want 20", ex_a);
    end
    mem_reg_write = 0; wb_reg_write = 0;
    id_rs = 0; id_rs_data = 32'h77;
    step();
    mem_reg_write = 1; mem_dst = 0; mem_result = 32'h10;
    wb_reg_write = 1; wb_dst = 0; wb_result = 32'h20;
    #1;
    checks++;
    if (ex_a !== 32'h77) begin
      fails++;
      $display("FAIL fwd_r0 got %h want 77", ex_a);
    end
  endtask

  task automatic test_imm_store();
    clear_inputs();
    id_valid = 1; id_alu_op = 3'b010;
    id_rt = 6; id_rt_data = 32'h11;
    id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
    id_mem_write = 1;
    step();
    mem_reg_write = 1; mem_dst = 6; mem_result = 32'h55;
    #1;
    checks++;
    if (ex_b !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL imm_b got %h want fffffffc", ex_b);
    end
    checks++;
    if (ex_store_data !== 32'h55) begin
      fails++;
      $display("FAIL store_fwd got %h want 55", ex_store_data);
    end
  endtask

  task automatic load_into_ex(input logic [4:0] d);
    clear_inputs();
    id_valid = 1; id_alu_op = 3'b010;
    id_rt = d; id_reg_write = 1;
    id_mem_read = 1; id_mem_to_reg = 1;
    step();
    clear_inputs();
    id_valid = 1; id_alu_op = 3'b010;
    id_rs = d; id_rt = 5; id_rd = 7;
    id_reg_dst = 1; id_reg_write = 1;
  endtask

  task automatic test_load_use();
    load_into_ex(5'd4);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL lu_stall got %b want 1", stall);
    end
    step();
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
         ex_mem_to_reg, stall} !== 6'b0) begin
      fails++;
      $display("FAIL lu_bubble got v=%b rw=%b mr=%b st=%b",
               ex_valid, ex_reg_write, ex_mem_read, stall);
    end
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_dst !== 5'd7
        || ex_reg_write !== 1'b1) begin
      fails++;
      $display("FAIL lu_enter got v=%b dst=%0d want 1/7",
               ex_valid, ex_dst);
    end
    load_into_ex(5'd0);
    id_rt = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL lu_r0 got %b want 0", stall);
    end
  endtask

  task automatic test_flush();
    load_into_ex(5'd4);
    flush = 1;
    step();
    checks++;
    if (ex_valid !== 0 || ex_reg_write !== 0
        || ex_mem_write !== 0) begin
      fails++;
      $display("FAIL flush_stall got v=%b rw=%b mw=%b want 0",
               ex_valid, ex_reg_write, ex_mem_write);
    end
    flush = 0;
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_dst !== 5'd7) begin
      fails++;
      $display("FAIL flush_one_bubble got v=%b dst=%0d",
               ex_valid, ex_dst);
    end
    clear_inputs();
    id_valid = 1; id_mem_write = 1; id_alu_src = 1;
    id_rs = 2; id_rt = 3; id_alu_op = 3'b010;
    flush = 1;
    step();
    checks++;
    if (ex_mem_write !== 1'b0 || ex_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_sw got mw=%b v=%b want 0",
               ex_mem_write, ex_valid);
    end
  endtask

  task automatic test_dst();
    clear_inputs();
    id_valid = 1; id_reg_write = 1;
    id_rd = 9; id_rt = 5; id_reg_dst = 1;
    step();
    checks++;
    if (ex_dst !== 5'd9) begin
      fails++;
      $display("FAIL dst_rd got %0d want 9", ex_dst);
    end
    id_reg_dst = 0;
    step();
    checks++;
    if (ex_dst !== 5'd5) begin
      fails++;
      $display("FAIL dst_rt got %0d want 5", ex_dst);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_id();
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) == 0);
      mem_reg_write = 1'($urandom);
      mem_dst = 5'($urandom_range(0, 7));
      mem_result = $urandom;
      wb_reg_write = 1'($urandom);
      wb_dst = 5'($urandom_range(0, 7));
      wb_result = $urandom;
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL rand[%0d] got %h want %h",
                 i, dut_vec, exp_vec());
      end
      step();
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_forward();
    test_imm_store();
    test_load_use();
    test_flush();
    test_dst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage that feeds the EX-stage ALU: alu_op[2:0], operands a/b, shamt[4:0].
- Captures decoded operands and control from ID every cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles; honours branch flush.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID slot holds a real instruction.
- id_alu_op  input  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 SLL, 101 SRL.
- id_rs, id_rt, id_rd  input  RW  register indices.
- id_rs_data, id_rt_data  input  DW  register-file read data.
- id_imm  input  DW  sign-extended immediate.
- id_shamt  input  5  shift amount.
- id_alu_src  input  1  1: b = immediate.
- id_reg_dst  input  1  1: destination = rd, else rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1  control bits.
- flush  input  1  branch taken; kill instruction entering EX.
- mem_reg_write  input  1  EX/MEM writes a register.
- mem_dst  input  RW  EX/MEM destination.
- mem_result  input  DW  EX/MEM ALU result.
- wb_reg_write  input  1  MEM/WB writes a register.
- wb_dst  input  RW  MEM/WB destination.
- wb_result  input  DW  MEM/WB write-back value.
- stall  output  1  hold PC and IF/ID (load-use).
- ex_valid  output  1  EX slot valid.
- ex_alu_op  output  3  to ALU op.
- ex_a, ex_b  output  DW  forwarded ALU operands.
- ex_shamt  output  5  to ALU shamt.
- ex_store_data  output  DW  forwarded rt value for stores.
- ex_dst  output  RW  resolved destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1  control for later stages.

Behaviour:
- Registered state: valid, alu_op, rs, rt, dst, rs_data, rt_data, imm, shamt, alu_src, and the four control bits.
- Latency: ID values present before edge N appear on ex_* in cycle N+1.
- dst is captured as id_reg_dst ? id_rd : id_rt.
- Reset: all registered state is 0. Resulting outputs:
  - ex_valid = 0, ex_alu_op = 000, ex_a = ex_b = ex_store_data = 0, ex_shamt = 0, ex_dst = 0.
  - All control outputs = 0; stall = 0.
  - Reset overrides flush and stall.
- Load-use stall (combinational):
  - stall = id_valid & ex_valid & ex_mem_read & (ex_dst != 0) & (ex_dst == id_rs | ex_dst == id_rt).
  - rt is always compared, even when unused (conservative).
- Bubble: on an edge where stall or flush is 1, load valid = 0, all control = 0, alu_op = 000, data/index fields = 0. Flush takes priority; flush and stall together still give one bubble.
- The upstream ID contents are held by the IF/ID stage while stall is high; this block re-samples them the next cycle.
- Forwarding for rs (combinational, from registered rs):
  - If mem_reg_write & mem_dst != 0 & mem_dst == rs, use mem_result.
  - Else if wb_reg_write & wb_dst != 0 & wb_dst == rs, use wb_result.
  - Else use rs_data.
  - MEM beats WB when both match.
- Forwarding for rt: same rule, producing fwd_rt.
- Register 0 is never forwarded.
- Operand outputs:
  - ex_a = fwd_rs.
  - ex_b = alu_src ? imm : fwd_rt.
  - ex_store_data = fwd_rt always.
  - ex_shamt = registered shamt.
- Forwarding applies regardless of ex_valid. Bubble control bits are 0, so bubbles have no effect downstream.
- No internal overflow/width conversion; all data paths are DW wide and unmodified.

Test Plan:
- Reset: assert reset 2 cycles with random ID inputs -> all outputs 0, stall 0. The cycle after deassert, the ID instruction (ADD rs=1 data 5, rt=2 data 7) appears with ex_a = 5, ex_b = 7, ex_alu_op = 010.
- EX/MEM forward with priority: EX holds rs=3. mem_reg_write = 1, mem_dst = 3, mem_result = 0x10; wb_reg_write = 1, wb_dst = 3, wb_result = 0x20 -> ex_a = 0x10. Drop mem_reg_write -> ex_a = 0x20. Set mem_dst = 0 with rs=0 -> ex_a = rs_data.
- Immediate vs. store data: alu_src = 1, imm = 0xFFFFFFFC, rt forwarded as 0x55 -> ex_b = 0xFFFFFFFC, ex_store_data = 0x55.
- Load-use: EX holds lw (mem_read = 1, dst = 4); ID presents add with rs = 4 -> stall = 1 that cycle. Next cycle ex_valid = 0, all control 0, stall = 0, and the add enters the cycle after. Repeat with dst = 0 -> no stall.
- Flush with stall together: flush = 1 while stall = 1 -> exactly one bubble, ex_reg_write = 0, ex_mem_write = 0. Flush alone on a valid sw -> ex_mem_write = 0 next cycle.
- Destination select: reg_dst = 1, rd = 9, rt = 5 -> ex_dst = 9; reg_dst = 0 -> ex_dst = 5.
